acorn128_decrypt: RTL and testbench

- ACORN-128 decryption core. Counterpart of the bit-serial encryption block; shares its 293-bit state, keystream and state-update definitions.
- Takes the post-init/post-AD state and a 128-bit ciphertext block. Recovers one plaintext bit per clock (m = c ^ ks) and feeds the recovered bit back into the state update.
- Runs the 512-step padding phase. Hands plaintext plus the final state to the tag-generation stage.

---
 rtl/acorn128_pkg.sv | 77 +++++++
 rtl/acorn128_decrypt_if.sv | 27 ++
 rtl/acorn128_step.sv | 17 +
 rtl/acorn128_decrypt.sv | 172 +++++++++++++++++
 tb/tb_acorn128_decrypt.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acorn128_pkg.sv
// Shared ACORN-128 definitions: state width, block sizes, phase encoding, LFSR taps
// and the keystream / feedback / state-update functions used by both cipher paths.
package acorn128_pkg;

  localparam int STATE_W  = 293;
  localparam int CT_W     = 128;
  localparam int PAD_W    = 256;
  localparam int CNT_W    = 9;
  localparam int CT_IDX_W = $clog2(CT_W);

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_DATA = 3'd1,
    PH_PAD1 = 3'd2,
    PH_PAD2 = 3'd3,
    PH_DONE = 3'd4
  } phase_e;

  // Six LFSR segments, applied top-down so each tap still sees its pre-step value.
  localparam int LFSR_N = 6;
  localparam int LFSR_DST [LFSR_N] = '{289, 230, 193, 154, 107, 61};
  localparam int LFSR_TA  [LFSR_N] = '{235, 196, 160, 111, 66, 23};
  localparam int LFSR_TB  [LFSR_N] = '{230, 193, 154, 107, 61, 0};

  localparam int KS_L0 = 12;
  localparam int KS_L1 = 154;
  localparam int KS_MAJ [3] = '{235, 61, 193};
  localparam int KS_CH  [3] = '{230, 111, 66};

  localparam int FB_L0  = 0;
  localparam int FB_INV = 107;
  localparam int FB_CA  = 196;
  localparam int FB_MAJ [3] = '{244, 23, 160};

  function automatic logic maj_f(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch_f(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic state_t lfsr128_f(input state_t s);
    state_t t;
    t = s;
    for (int i = 0; i < LFSR_N; i++) begin
      t[LFSR_DST[i]] = t[LFSR_DST[i]] ^ t[LFSR_TA[i]] ^ t[LFSR_TB[i]];
    end
    return t;
  endfunction

  function automatic logic ksg128_f(input state_t s);
    state_t t;
    t = lfsr128_f(s);
    return t[KS_L0] ^ t[KS_L1]
         ^ maj_f(t[KS_MAJ[0]], t[KS_MAJ[1]], t[KS_MAJ[2]])
         ^ ch_f(t[KS_CH[0]], t[KS_CH[1]], t[KS_CH[2]]);
  endfunction

  function automatic logic fbk128_f(input state_t s, input logic ca, input logic cb);
    state_t t;
    t = lfsr128_f(s);
    return t[FB_L0] ^ ~t[FB_INV]
         ^ maj_f(t[FB_MAJ[0]], t[FB_MAJ[1]], t[FB_MAJ[2]])
         ^ (ca & t[FB_CA]) ^ (cb & ksg128_f(s));
  endfunction

  function automatic state_t update128_f(input state_t s, input logic m,
                                         input logic ca, input logic cb);
    state_t t;
    t = lfsr128_f(s);
    return {fbk128_f(s, ca, cb) ^ m, t[STATE_W-1:1]};
  endfunction

endpackage

// File: rtl/acorn128_decrypt_if.sv
// Request/result bundle of the ACORN-128 decryption core.
// ACORN_DEC_EARLY_PT_EN adds the pt_valid early-plaintext strobe.
interface acorn128_decrypt_if;
  import acorn128_pkg::*;

  logic            start;
  state_t          state_in;
  logic [CT_W-1:0] cipher_in;
  logic            busy;
  logic            done;
  logic [CT_W-1:0] plaintext_out;
  state_t          state_out;
`ifdef ACORN_DEC_EARLY_PT_EN
  logic            pt_valid;

  modport master (output start, state_in, cipher_in,
                  input  busy, done, plaintext_out, state_out, pt_valid);
  modport slave  (input  start, state_in, cipher_in,
                  output busy, done, plaintext_out, state_out, pt_valid);
`else
  modport master (output start, state_in, cipher_in,
                  input  busy, done, plaintext_out, state_out);
  modport slave  (input  start, state_in, cipher_in,
                  output busy, done, plaintext_out, state_out);
`endif

endinterface

// File: rtl/acorn128_step.sv
// One ACORN-128 step: keystream bit from the current state and the next state
// for a given message bit and control bits.
module acorn128_step
  import acorn128_pkg::*;
(
  input  state_t s,
  input  logic   m,
  input  logic   ca,
  input  logic   cb,
  output logic   ks,
  output state_t s_next
);

  assign ks     = ksg128_f(s);
  assign s_next = update128_f(s, m, ca, cb);

endmodule

// File: rtl/acorn128_decrypt.sv
// Bit-serial ACORN-128 decryption: 128 ciphertext steps then 2x256 padding steps.
// ACORN_DEC_EARLY_PT_EN releases plaintext with a pt_valid pulse when DATA ends.
module acorn128_decrypt
  import acorn128_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  acorn128_decrypt_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CT_LAST  = CNT_W'(CT_W - 1);
  localparam logic [CNT_W-1:0] CNT_PAD_LAST = CNT_W'(PAD_W - 1);

  phase_e              phase_r, phase_n_s;
  logic [CNT_W-1:0]    cnt_r, cnt_n_s;
  state_t              s_r, s_next_s, state_out_r;
  logic [CT_W-1:0]     cipher_r, pt_r, pt_n_s, plaintext_out_r;
  logic                busy_r, done_r;
  logic                accept_s, step_s, last_s, m_s, ca_s, ks_s;
  logic [CT_IDX_W-1:0] idx_s;

  assign idx_s = cnt_r[CT_IDX_W-1:0];

  acorn128_step u_step (
    .s      (s_r),
    .m      (m_s),
    .ca     (ca_s),
    .cb     (1'b0),
    .ks     (ks_s),
    .s_next (s_next_s)
  );

  // Next phase, step counter and the per-step message/control bits
  always_comb begin
    phase_n_s = phase_r;
    cnt_n_s   = cnt_r;
    pt_n_s    = pt_r;
    accept_s  = 1'b0;
    step_s    = 1'b0;
    last_s    = 1'b0;
    m_s       = 1'b0;
    ca_s      = 1'b0;
    case (phase_r)
      PH_IDLE: begin
        if (bus.start) begin
          accept_s  = 1'b1;
          phase_n_s = PH_DATA;
          cnt_n_s   = CNT_ZERO;
        end else begin
          phase_n_s = PH_IDLE;
        end
      end
      PH_DATA: begin
        step_s        = 1'b1;
        ca_s          = 1'b1;
        m_s           = cipher_r[idx_s] ^ ks_s;
        pt_n_s[idx_s] = m_s;
        last_s        = (cnt_r == CNT_CT_LAST);
      end
      PH_PAD1: begin
        step_s = 1'b1;
        ca_s   = 1'b1;
        m_s    = (cnt_r == CNT_ZERO);
        last_s = (cnt_r == CNT_PAD_LAST);
      end
      PH_PAD2: begin
        step_s = 1'b1;
        last_s = (cnt_r == CNT_PAD_LAST);
      end
      PH_DONE: begin
        phase_n_s = PH_IDLE;
        cnt_n_s   = CNT_ZERO;
      end
      default: begin
        phase_n_s = PH_IDLE;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
    // Shared counter advance / phase hand-off for the three stepping phases
    if (step_s) begin
      if (last_s) begin
        cnt_n_s = CNT_ZERO;
        case (phase_r)
          PH_DATA: phase_n_s = PH_PAD1;
          PH_PAD1: phase_n_s = PH_PAD2;
          PH_PAD2: phase_n_s = PH_DONE;
          default: phase_n_s = PH_IDLE;
        endcase
      end else begin
        cnt_n_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_n_s = cnt_n_s;
    end
  end

  // Control registers: phase, counter, busy/done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PH_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      phase_r <= phase_n_s;
      cnt_r   <= cnt_n_s;
      busy_r  <= (phase_n_s == PH_DATA) || (phase_n_s == PH_PAD1) || (phase_n_s == PH_PAD2);
      done_r  <= (phase_n_s == PH_DONE);
    end
  end

  // Working state, latched ciphertext and plaintext being recovered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r      <= {STATE_W{1'b0}};
      cipher_r <= {CT_W{1'b0}};
      pt_r     <= {CT_W{1'b0}};
    end else if (accept_s) begin
      s_r      <= bus.state_in;
      cipher_r <= bus.cipher_in;
      pt_r     <= {CT_W{1'b0}};
    end else if (step_s) begin
      s_r      <= s_next_s;
      pt_r     <= pt_n_s;
    end
  end

  // Final state is taken from the last padding step as DONE is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out_r <= {STATE_W{1'b0}};
    end else if ((phase_r == PH_PAD2) && last_s) begin
      state_out_r <= s_next_s;
    end
  end

`ifdef ACORN_DEC_EARLY_PT_EN
  logic pt_valid_r;

  // Plaintext released as DATA ends, including the bit recovered on that step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plaintext_out_r <= {CT_W{1'b0}};
      pt_valid_r      <= 1'b0;
    end else if ((phase_r == PH_DATA) && last_s) begin
      plaintext_out_r <= pt_n_s;
      pt_valid_r      <= 1'b1;
    end else begin
      pt_valid_r      <= 1'b0;
    end
  end

  assign bus.pt_valid = pt_valid_r;
`else
  // Plaintext released together with the final state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plaintext_out_r <= {CT_W{1'b0}};
    end else if ((phase_r == PH_PAD2) && last_s) begin
      plaintext_out_r <= pt_r;
    end
  end
`endif

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.plaintext_out = plaintext_out_r;
  assign bus.state_out     = state_out_r;

endmodule

// File: tb/tb_acorn128_decrypt.sv
// Bench for acorn128_decrypt: ciphertext comes from an in-bench ACORN-128 encryption
// model; the decryptor must recover the plaintext and the model's final state.
module tb_acorn128_decrypt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  acorn128_decrypt_if bus();

  acorn128_decrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (ACORN-128 rules on a bit vector) ----------------
  function automatic logic [292:0] mix(input logic [292:0] s);
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    return s;
  endfunction

  function automatic logic m_maj(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  function automatic logic m_ks(input logic [292:0] s);
    logic [292:0] t;
    t = mix(s);
    return t[12] ^ t[154] ^ m_maj(t[235], t[61], t[193]) ^ (t[230] ? t[111] : t[66]);
  endfunction

  function automatic logic [292:0] m_next(input logic [292:0] s, input logic m, input logic ca);
    logic [292:0] t;
    logic f;
    t = mix(s);
    f = t[0] ^ !t[107] ^ m_maj(t[244], t[23], t[160]) ^ (ca & t[196]);
    return {f ^ m, t[292:1]};
  endfunction

  task automatic model_encrypt(input logic [292:0] v, input logic [127:0] p,
                               output logic [127:0] c, output logic [292:0] sf);
    logic [292:0] s;
    s = v;
    for (int i = 0; i < 128; i++) begin
      c[i] = p[i] ^ m_ks(s);
      s = m_next(s, p[i], 1'b1);
    end
    for (int j = 0; j < 256; j++) s = m_next(s, (j == 0), 1'b1);
    for (int j = 0; j < 256; j++) s = m_next(s, 1'b0, 1'b0);
    sf = s;
  endtask

  function automatic logic [292:0] rand293();
    logic [319:0] w;
    for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom;
    return w[292:0];
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [127:0] res_pt;
  logic [292:0] res_st;
  int           res_lat;
  int           res_done_cyc;
`ifdef ACORN_DEC_EARLY_PT_EN
  int           ptv_n;
  int           ptv_k;
  logic [127:0] ptv_pt;
`endif

  // Starts a block from the IDLE cycle and waits for done; mode 1 injects stray starts.
  task automatic run_block(input logic [292:0] v, input logic [127:0] c, input int mode);
    bus.state_in  = v;
    bus.cipher_in = c;
    bus.start     = 1'b1;
    res_lat       = -1;
`ifdef ACORN_DEC_EARLY_PT_EN
    ptv_n = 0;
    ptv_k = -1;
    ptv_pt = '0;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && (k == 9 || k == 399)) begin
        bus.start     = 1'b1;
        bus.cipher_in = ~c;
        bus.state_in  = ~v;
      end else begin
        bus.start = 1'b0;
      end
`ifdef ACORN_DEC_EARLY_PT_EN
      if (bus.pt_valid === 1'b1) begin
        ptv_n++;
        ptv_k  = k;
        ptv_pt = bus.plaintext_out;
      end
`endif
      if (bus.done === 1'b1) begin
        res_lat = k;
        break;
      end
    end
    bus.start    = 1'b0;
    res_done_cyc = cyc;
    res_pt       = bus.plaintext_out;
    res_st       = bus.state_out;
    chk("latency", res_lat, 640);
    chk("busy_at_done", bus.busy, 1'b0);
  endtask

  typedef struct {
    logic [292:0] v;
    logic [127:0] c;
    logic [127:0] exp_pt;
    logic [292:0] exp_st;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [319:0] w;
    logic [127:0] p;
    int           d1;
    bit           seen;

    bus.start     = 1'b0;
    bus.state_in  = '0;
    bus.cipher_in = '0;

    // vector 0: fixed state and the fixed plaintext; the rest random
    w = {10{32'h9E37_79B9}};
    vecs[0].v = w[292:0];
    vecs[0].exp_pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    vecs[1].v = rand293();
    vecs[1].exp_pt = 128'h0;
    vecs[2].v = '0;
    vecs[2].exp_pt = {128{1'b1}};
    for (int i = 3; i < 5; i++) begin
      vecs[i].v = rand293();
      vecs[i].exp_pt = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 5; i++) begin
      p = vecs[i].exp_pt;
      model_encrypt(vecs[i].v, p, vecs[i].c, vecs[i].exp_st);
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_pt", bus.plaintext_out, 128'h0);
    chk("rst_state", bus.state_out, 293'h0);
`ifdef ACORN_DEC_EARLY_PT_EN
    chk("rst_pt_valid", bus.pt_valid, 1'b0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // table-driven round trips
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].v, vecs[i].c, 0);
      chk($sformatf("pt[%0d]", i), res_pt, vecs[i].exp_pt);
      chk($sformatf("state[%0d]", i), res_st, vecs[i].exp_st);
`ifdef ACORN_DEC_EARLY_PT_EN
      chk($sformatf("ptv_count[%0d]", i), ptv_n, 1);
      chk($sformatf("ptv_cycle[%0d]", i), ptv_k, 128);
      chk($sformatf("ptv_pt[%0d]", i), ptv_pt, vecs[i].exp_pt);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("done_width[%0d]", i), bus.done, 1'b0);
    end

    // stray starts at E10 and E400, then start held through the DONE cycle
    run_block(vecs[0].v, vecs[0].c, 1);
    chk("ignore_pt", res_pt, vecs[0].exp_pt);
    chk("ignore_state", res_st, vecs[0].exp_st);
    bus.start     = 1'b1;
    bus.cipher_in = vecs[3].c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("start_in_done_ignored", bus.busy, 1'b0);

    // reset pulse mid-operation at E300
    bus.state_in  = vecs[1].v;
    bus.cipher_in = vecs[1].c;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_pt", bus.plaintext_out, 128'h0);
    chk("midrst_state", bus.state_out, 293'h0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (700) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);
    run_block(vecs[1].v, vecs[1].c, 0);
    chk("after_rst_pt", res_pt, vecs[1].exp_pt);
    chk("after_rst_state", res_st, vecs[1].exp_st);

    // back-to-back: second start in the IDLE cycle right after DONE
    @(posedge clk);
    #1;
    run_block(vecs[3].v, vecs[3].c, 0);
    chk("b2b_pt1", res_pt, vecs[3].exp_pt);
    chk("b2b_state1", res_st, vecs[3].exp_st);
    d1 = res_done_cyc;
    @(posedge clk);
    #1;
    run_block(vecs[4].v, vecs[4].c, 0);
    chk("b2b_pt2", res_pt, vecs[4].exp_pt);
    chk("b2b_state2", res_st, vecs[4].exp_st);
    // cycles strictly between the two done pulses
    chk("b2b_gap", res_done_cyc - d1 - 1, 641);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
